// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment display driver: hex decode, per-digit scan with
// anti-ghosting blank interval, leading-zero blanking and tear-free loads.
module seg_scan_mux #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned BLANK_CYC      = 500,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  en,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [VAL_W-1:0]  pend_val;
  logic [DIGITS-1:0] pend_dp;
  logic              pend_v;
  logic [VAL_W-1:0]  disp_val;
  logic [DIGITS-1:0] disp_dp;

  logic              slot_end_c;
  logic              wrap_c;
  logic [DIGITS-1:0] lz_mask_c;
  logic              hi_nz_c;
  logic [3:0]        cur_nib_c;
  logic              cur_dp_c;
  logic              cur_blank_c;
  logic [7:0]        seg_c;
  logic [DIGITS-1:0] an_c;

  // Active-high a..g for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0:    hex7 = 7'b1111110;
      4'h1:    hex7 = 7'b0110000;
      4'h2:    hex7 = 7'b1101101;
      4'h3:    hex7 = 7'b1111001;
      4'h4:    hex7 = 7'b0110011;
      4'h5:    hex7 = 7'b1011011;
      4'h6:    hex7 = 7'b1011111;
      4'h7:    hex7 = 7'b1110000;
      4'h8:    hex7 = 7'b1111111;
      4'h9:    hex7 = 7'b1111011;
      4'hA:    hex7 = 7'b1110111;
      4'hB:    hex7 = 7'b0011111;
      4'hC:    hex7 = 7'b1001110;
      4'hD:    hex7 = 7'b0111101;
      4'hE:    hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  assign slot_end_c = (cnt == CNT_MAX);
  assign wrap_c     = en & slot_end_c & (idx == IDX_MAX);

  // Prescaler and digit index; both freeze while scanning is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (slot_end_c) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Double buffer: disp only changes at the frame wrap, so frames never tear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_v   <= 1'b0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else if (wrap_c) begin
      pend_v <= 1'b0;
      if (load) begin
        disp_val <= value;
        disp_dp  <= dp_in;
      end else if (pend_v) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
      pend_v   <= 1'b1;
    end
  end

  // Digit i>0 is blanked when it and every more-significant nibble are zero.
  always_comb begin
    lz_mask_c = '0;
    hi_nz_c   = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      hi_nz_c      = hi_nz_c | (disp_val[4*i +: 4] != 4'h0);
      lz_mask_c[i] = blank_lz & ~hi_nz_c;
    end
  end

  always_comb begin
    cur_nib_c   = 4'h0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib_c   = disp_val[4*i +: 4];
        cur_dp_c    = disp_dp[i];
        cur_blank_c = lz_mask_c[i];
      end
    end
  end

  always_comb begin
    seg_c = 8'h00;
    an_c  = '0;
    if (en) begin
      seg_c = {(cur_blank_c ? 7'h00 : hex7(cur_nib_c)), cur_dp_c};
      if (cnt >= CNT_BLANK) an_c = DIGITS'(1) << idx;
    end
  end

  // Output registers; pin polarity is applied only here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= {8{ACTIVE_LOW_SEG}};
      an         <= {DIGITS{ACTIVE_LOW_AN}};
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_c ^ {8{ACTIVE_LOW_SEG}};
      an         <= an_c ^ {DIGITS{ACTIVE_LOW_AN}};
      frame_done <= wrap_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: frame-position reference model feeding a scoreboard,
// plus directed checks on decoded patterns, blanking, buffering and reset.
module tb_seg_scan_mux;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned BLANK_CYC = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  seg_scan_mux #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC),
    .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .en(en), .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference state: position within the 16-cycle frame plus both buffers.
  int          m_pos;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pend_dp;
  logic        m_pend_v;

  logic [7:0] seen_seg [4];
  int         lit_cnt  [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pin-level (active-low) pattern with dp off.
  function automatic logic [7:0] seg_low(input logic [3:0] h);
    case (h)
      4'h0: seg_low = 8'h03;  4'h1: seg_low = 8'h9F;
      4'h2: seg_low = 8'h25;  4'h3: seg_low = 8'h0D;
      4'h4: seg_low = 8'h99;  4'h5: seg_low = 8'h49;
      4'h6: seg_low = 8'h41;  4'h7: seg_low = 8'h1F;
      4'h8: seg_low = 8'h01;  4'h9: seg_low = 8'h09;
      4'hA: seg_low = 8'h11;  4'hB: seg_low = 8'hC1;
      4'hC: seg_low = 8'h63;  4'hD: seg_low = 8'h85;
      4'hE: seg_low = 8'h61;  default: seg_low = 8'h71;
    endcase
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    int d, c;
    e.an  = 4'hF;
    e.seg = 8'hFF;
    e.fd  = 1'b0;
    if (en) begin
      d = m_pos / 4;
      c = m_pos % 4;
      e.an = (c >= 1) ? ~(4'b0001 << d) : 4'hF;
      if (blank_lz && d != 0 && (m_disp >> (4*d)) == 16'h0) e.seg = 8'hFF;
      else e.seg = seg_low(m_disp[4*d +: 4]);
      if (m_dp[d]) e.seg[0] = 1'b0;
      e.fd = (m_pos == 15);
    end
    return e;
  endfunction

  task automatic model_update();
    if (en && m_pos == 15) begin
      m_pos = 0;
      if (load) begin
        m_disp = value;
        m_dp   = dp_in;
      end else if (m_pend_v) begin
        m_disp = m_pend;
        m_dp   = m_pend_dp;
      end
      m_pend_v = 1'b0;
    end else begin
      if (en) m_pos++;
      if (load) begin
        m_pend    = value;
        m_pend_dp = dp_in;
        m_pend_v  = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_pos     = 0;
    m_disp    = 16'h0;
    m_dp      = 4'h0;
    m_pend    = 16'h0;
    m_pend_dp = 4'h0;
    m_pend_v  = 1'b0;
    sbq.delete();
  endtask

  task automatic clear_rec();
    for (int d = 0; d < 4; d++) begin
      seen_seg[d] = 8'h00;
      lit_cnt[d]  = 0;
    end
  endtask

  // One clock: predict, advance the model, then compare the DUT's registered outputs.
  task automatic step();
    exp_t ex;
    sbq.push_back(model_exp());
    model_update();
    @(posedge clk);
    #1;
    ex = sbq.pop_front();
    check("an", 32'(an), 32'(ex.an));
    check("seg", 32'(seg), 32'(ex.seg));
    check("frame_done", 32'(frame_done), 32'(ex.fd));
    for (int d = 0; d < 4; d++) begin
      if (an == ~(4'b0001 << d)) begin
        seen_seg[d] = seg;
        lit_cnt[d]++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_fd(input int max, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!frame_done && k < max);
    if (!frame_done) check("fd_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
    value = v;
    dp_in = dp;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    check({tag, "_d0"}, 32'(seen_seg[0]), 32'(e0));
    check({tag, "_d1"}, 32'(seen_seg[1]), 32'(e1));
    check({tag, "_d2"}, 32'(seen_seg[2]), 32'(e2));
    check({tag, "_d3"}, 32'(seen_seg[3]), 32'(e3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    model_reset();
    clear_rec();

    // Asynchronous reset with no clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_fd", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    run(10);
    check("idle_an", 32'(an), 32'hF);
    check("idle_seg", 32'(seg), 32'hFF);

    // Decode and scan order.
    load_val(16'h1234, 4'h0);
    en = 1'b1;
    wait_fd(40, k);
    clear_rec();
    run(16);
    check_frame("scan1234", 8'h99, 8'h0D, 8'h25, 8'h9F);
    for (int d = 0; d < 4; d++) check("lit_cycles", 32'(lit_cnt[d]), 32'd3);
    wait_fd(40, k);
    check("frame_period", 32'(k), 32'd16);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load_val(16'h0070, 4'h0);
    wait_fd(40, k);
    clear_rec();
    run(16);
    check_frame("lz0070", 8'h03, 8'h1F, 8'hFF, 8'hFF);
    load_val(16'h0000, 4'h0);
    wait_fd(40, k);
    clear_rec();
    run(16);
    check_frame("lz0000", 8'h03, 8'hFF, 8'hFF, 8'hFF);
    load_val(16'h0000, 4'b0100);
    wait_fd(40, k);
    clear_rec();
    run(16);
    check_frame("lzdp", 8'h03, 8'hFF, 8'hFE, 8'hFF);

    // Tear-free loads mid-frame; the last load wins at the wrap.
    blank_lz = 1'b0;
    run(5);
    clear_rec();
    load_val(16'hAAAA, 4'h0);
    run(2);
    load_val(16'hBBBB, 4'h0);
    wait_fd(40, k);
    check("old_d2", 32'(seen_seg[2]), 32'h02);
    check("old_d3", 32'(seen_seg[3]), 32'h03);
    clear_rec();
    run(16);
    check_frame("bbbb", 8'hC1, 8'hC1, 8'hC1, 8'hC1);

    // Load coincident with the wrap cycle.
    run(15);
    load_val(16'h1234, 4'h0);
    check("wrap_load_fd", 32'(frame_done), 32'd1);
    clear_rec();
    run(16);
    check_frame("wrapload", 8'h99, 8'h0D, 8'h25, 8'h9F);

    // Enable pause inside digit 1's slot.
    run(6);
    en = 1'b0;
    step();
    check("pause_an", 32'(an), 32'hF);
    run(19);
    en = 1'b1;
    clear_rec();
    wait_fd(60, k);
    check("resume_to_fd", 32'(k), 32'd10);
    check("resume_d1_lit", 32'(lit_cnt[1]), 32'd2);

    // Mid-frame async reset discards both buffers.
    run(9);
    load_val(16'h5678, 4'h0);
    check("d2_lit", 32'(an), 32'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'hFF);
    check("mid_rst_fd", 32'(frame_done), 32'h0);
    #1 rst_n = 1'b1;
    model_reset();
    wait_fd(40, k);
    clear_rec();
    run(16);
    check_frame("post_rst", 8'h03, 8'h03, 8'h03, 8'h03);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multiplexed seven-segment display driver for the board's N-digit common-anode or common-cathode display. It takes a packed hex value, decodes each nibble with the team's standard hex-to-segment table, and time-multiplexes the digits with a programmable per-digit dwell and an anti-ghosting blank interval. It adds optional leading-zero blanking, per-digit decimal points, tear-free double-buffered loads, and a frame-done strobe. It sits between user logic and the display pins.

## Interface
- DIGITS, 4: number of digits, 1..8.
- CLK_DIV, 50000: clock cycles per digit slot, ≥2.
- BLANK_CYC, 500: cycles at slot start with all anodes off; 0 ≤ BLANK_CYC < CLK_DIV.
- ACTIVE_LOW_SEG, 1: 1 = segment outputs inverted at pins.
- ACTIVE_LOW_AN, 1: 1 = anode outputs inverted at pins.

- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- value  in  4*DIGITS  hex digits; nibble i = digit i; digit 0 = value[3:0] = rightmost.
- dp_in  in  DIGITS  decimal point per digit.
- load  in  1  capture strobe for value/dp_in.
- blank_lz  in  1  enable leading-zero blanking (live, not buffered).
- en  in  1  scan enable.
- seg  out  8  {a,b,c,d,e,f,g,dp}; a = seg[7], dp = seg[0].
- an  out  DIGITS  digit enables; an[i] drives digit i.
- frame_done  out  1  one-cycle pulse per completed scan frame.

## Operation
- Internal polarity is active-high; ACTIVE_LOW_* applies inversion only at the output registers.
- Decode, active-high a..g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- State: prescaler cnt (0..CLK_DIV-1), digit index idx (0..DIGITS-1), pending buffer {pend_val, pend_dp, pend_v}, display buffer {disp_val, disp_dp}.
- When en=1: cnt increments each cycle. At cnt=CLK_DIV-1, cnt←0 and idx←idx+1, wrapping DIGITS-1→0. The wrap event is cnt=CLK_DIV-1 and idx=DIGITS-1.
- When en=0: cnt and idx hold. The next registered an is all-inactive and seg is all-off.
- Load buffering:
  - load=1 writes value and dp_in into pend and sets pend_v. A second load before the wrap overwrites it; the latest load wins.
  - At the wrap event: if load=1 in the same cycle, disp takes value and dp_in directly. Otherwise, if pend_v=1, disp takes pend. In both cases pend_v clears.
  - Loads are accepted regardless of en. disp changes only at a wrap, so a frame never mixes old and new digits.
- Leading-zero blanking: digit i (i>0) is blanked when blank_lz=1 and disp nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. A blanked digit has a..g off; its dp still follows disp_dp[i].
- Anode: active for idx only when en=1 and cnt ≥ BLANK_CYC; otherwise all anodes are inactive.

## Timing
- seg, an and frame_done are registered with asynchronous reset. Each reflects the state (cnt, idx, disp, en) of the previous cycle: 1-cycle latency.
- Reset values:
  - seg = all segments off (8'hFF if ACTIVE_LOW_SEG, else 8'h00).
  - an = all inactive.
  - frame_done = 0.
  - cnt = 0, idx = 0, disp = 0, pend_v = 0.
- rst_n assertion forces outputs inactive immediately, with no clock edge. Reset mid-frame discards pend and disp.
- frame_done is high for exactly the one cycle after the wrap event. A value loaded at least one cycle before the wrap is visible on digit 0 in the first active cycle of the following frame.
- Frame period = DIGITS*CLK_DIV cycles. Each digit is lit for CLK_DIV-BLANK_CYC cycles per frame.
- DIGITS=1: idx stays 0 and a wrap occurs every slot.

## Test plan
Bench parameters: DIGITS=4, CLK_DIV=4, BLANK_CYC=1, both active-low.

- Reset: assert rst_n=0 with no clock → an=4'b1111, seg=8'hFF, frame_done=0. Release, hold en=0 for 10 cycles → outputs unchanged.
- Decode and scan: load 16'h1234, dp_in=0, en=1. After the first frame_done:
  - digit 0 (an=1110) seg=8'h99; digit 1 (an=1101) seg=8'h0D; digit 2 (an=1011) seg=8'h25; digit 3 (an=0111) seg=8'h9F.
  - Each digit is lit 3 cycles after 1 all-off cycle, in order 0→3, repeating every 16 cycles.
- Leading zeros, blank_lz=1:
  - value 16'h0070 → digits 3 and 2 show seg=8'hFF while their anode is active; digit 1 shows 8'h1F; digit 0 shows 8'h03.
  - value 16'h0000 → only digit 0 is lit, seg=8'h03.
  - dp_in=4'b0100 with value 16'h0000 → digit 2 shows seg=8'hFE.
- Tear-free load: load 16'hAAAA mid-frame, then 16'hBBBB two cycles later → the current frame keeps the old value, and the frame after frame_done shows 8'hC1 on every digit. Load coincident with the wrap cycle → applied in the immediately following frame.
- Enable pause: drop en in cycle 2 of digit 1's slot → an=1111 on the next cycle. Raise en 20 cycles later → digit 1 resumes with its remaining 2 slot cycles, and frame_done is delayed by 20 cycles.
- Async reset mid-frame: pulse rst_n low between clock edges while digit 2 is lit → an=1111 and seg=8'hFF before the next edge. After release, the display is blank (disp=0, digit 0 shows 8'h03 when blank_lz=0).
